// File: rtl/hc_sr04_responder.sv
// HC-SR04 ultrasonic sensor emulator: trigger-width check, burst delay, echo pulse of distance*58 us.
// Optional macro HC_SR04_JITTER_EN adds 0..15 us LFSR jitter to each echo width.
module hc_sr04_responder #(
  parameter int CLKS_PER_US = 100,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 200,
  parameter int MAX_CM      = 400,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       trigger,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       done,
  output logic       trig_err
);

  // state   | meaning
  // IDLE    | waiting for trig_s high
  // TRIG    | measuring trigger width
  // BURST   | emulated ultrasonic burst delay
  // ECHO    | echo high, width encodes distance
  // HOLDOFF | dead time, trigger ignored
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_BURST, S_ECHO, S_HOLDOFF} state_t;

  localparam int MIN_TRIG_CLKS = MIN_TRIG_US * CLKS_PER_US;
  localparam int TCW = $clog2(MIN_TRIG_CLKS + 1);
  localparam int PW  = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [TCW-1:0] TRIG_MIN = TCW'(MIN_TRIG_CLKS);
  localparam logic [PW-1:0]  PRE_LAST = PW'(CLKS_PER_US - 1);

  state_t           state_q, state_d;
  logic             en_q;
  logic [1:0]       sync_q;
  logic [TCW-1:0]   trig_cnt_q, trig_cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [15:0]      us_q, us_d;
  logic [8:0]       cm_q, cm_d;
  logic             echo_q, echo_d, done_q, done_d, err_q, err_d;
  logic             trig_s, us_tc;
  logic [15:0]      base_us, echo_us;
`ifdef HC_SR04_JITTER_EN
  logic [7:0]       lfsr_q, lfsr_d;
`endif

  assign trig_s   = sync_q[1];
  assign us_tc    = (pre_q == '0) && (us_q == 16'd0);
  assign echo     = echo_q;
  assign done     = done_q;
  assign trig_err = err_q;
  assign busy     = (state_q != S_IDLE);

  // Zero or beyond-range distance reports the no-target timeout width.
  assign base_us = ((cm_q == 9'd0) || ({7'd0, cm_q} > 16'(MAX_CM))) ?
                   16'(TIMEOUT_US) : {7'd0, cm_q} * 16'd58;
`ifdef HC_SR04_JITTER_EN
  assign echo_us = base_us + {12'd0, lfsr_q[3:0]};
`else
  assign echo_us = base_us;
`endif

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    pre_d      = (pre_q == '0) ? PRE_LAST : pre_q - PW'(1);
    us_d       = ((pre_q == '0) && (us_q != 16'd0)) ? us_q - 16'd1 : us_q;
    cm_d       = cm_q;
    echo_d     = echo_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef HC_SR04_JITTER_EN
    lfsr_d     = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (trig_s) begin
          state_d    = S_TRIG;
          trig_cnt_d = '0;
        end
      end
      S_TRIG: begin
        if (trig_s) begin
          if (trig_cnt_q != TRIG_MIN) trig_cnt_d = trig_cnt_q + TCW'(1);
        end else if (trig_cnt_q < TRIG_MIN) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cm_d    = distance_cm;
          state_d = S_BURST;
          pre_d   = PRE_LAST;
          us_d    = 16'(BURST_US - 1);
`ifdef HC_SR04_JITTER_EN
          lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
        end
      end
      S_BURST: begin
        if (us_tc) begin
          state_d = S_ECHO;
          echo_d  = 1'b1;
          pre_d   = PRE_LAST;
          us_d    = echo_us - 16'd1;
        end
      end
      S_ECHO: begin
        if (us_tc) begin
          state_d = S_HOLDOFF;
          echo_d  = 1'b0;
          done_d  = 1'b1;
          pre_d   = PRE_LAST;
          us_d    = 16'(HOLDOFF_US - 1);
        end
      end
      S_HOLDOFF: begin
        if (us_tc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // en_q makes the first edge after reset release a no-op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      sync_q     <= 2'b00;
      trig_cnt_q <= '0;
      pre_q      <= '0;
      us_q       <= 16'd0;
      cm_q       <= 9'd0;
      echo_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef HC_SR04_JITTER_EN
      lfsr_q     <= 8'hA5;
`endif
    end else begin
      en_q <= 1'b1;
      if (en_q) begin
        state_q    <= state_d;
        sync_q     <= {sync_q[0], trigger};
        trig_cnt_q <= trig_cnt_d;
        pre_q      <= pre_d;
        us_q       <= us_d;
        cm_q       <= cm_d;
        echo_q     <= echo_d;
        done_q     <= done_d;
        err_q      <= err_d;
`ifdef HC_SR04_JITTER_EN
        lfsr_q     <= lfsr_d;
`endif
      end
    end
  end

endmodule
